// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter in front of the single-port byte-writable data
//            memory: port 0 priority with a bounded streak, 1-cycle read return.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_read,
  input  logic [3:0]            p0_writeb,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  output logic                  p0_resp_valid,
  output logic [31:0]           p0_rdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_read,
  input  logic [3:0]            p1_writeb,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  output logic                  p1_resp_valid,
  output logic [31:0]           p1_rdata,
  output logic [3:0]            mem_writeb,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [3:0] C_MAX_STREAK = 4'(MAX_STREAK);

  logic [3:0] r_streak;
  logic       r_rd0;
  logic       r_rd1;
  logic       w_yield;
  logic       w_gnt0;
  logic       w_gnt1;

  // Port 1 wins a contended cycle only once port 0 has used up its streak.
  always_comb begin
    w_yield = p1_valid && (r_streak == C_MAX_STREAK);
    w_gnt0  = !rst && p0_valid && !w_yield;
    w_gnt1  = !rst && p1_valid && (!p0_valid || w_yield);
  end

  assign p0_ready = w_gnt0;
  assign p1_ready = w_gnt1;

  always_comb begin
    mem_read   = 1'b0;
    mem_writeb = 4'd0;
    mem_addr   = p0_addr;
    mem_wdata  = p0_wdata;
    if (w_gnt1) begin
      mem_read   = p1_read;
      mem_writeb = p1_writeb;
      mem_addr   = p1_addr;
      mem_wdata  = p1_wdata;
    end else if (w_gnt0) begin
      mem_read   = p0_read;
      mem_writeb = p0_writeb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= 4'd0;
      r_rd0    <= 1'b0;
      r_rd1    <= 1'b0;
    end else begin
      r_rd0 <= w_gnt0 && p0_read;
      r_rd1 <= w_gnt1 && p1_read;
      if (w_gnt0 && p1_valid) begin
        r_streak <= (r_streak == C_MAX_STREAK) ? r_streak : r_streak + 4'd1;
      end else begin
        r_streak <= 4'd0;
      end
    end
  end

  // A response landing in a reset cycle is discarded rather than delivered.
  assign p0_resp_valid = r_rd0 && !rst;
  assign p1_resp_valid = r_rd1 && !rst;
  assign p0_rdata      = p0_resp_valid ? mem_rdata : 32'd0;
  assign p1_rdata      = p1_resp_valid ? mem_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a memory and a
//            behavioural reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int AW = 11;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_valid, p0_ready, p0_read, p0_resp_valid;
  logic [3:0]    p0_writeb;
  logic [AW-1:0] p0_addr;
  logic [31:0]   p0_wdata, p0_rdata;
  logic          p1_valid, p1_ready, p1_read, p1_resp_valid;
  logic [3:0]    p1_writeb;
  logic [AW-1:0] p1_addr;
  logic [31:0]   p1_wdata, p1_rdata;
  logic [3:0]    mem_writeb;
  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .MAX_STREAK(MS)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_read(p0_read),
    .p0_writeb(p0_writeb), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_resp_valid(p0_resp_valid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_read(p1_read),
    .p1_writeb(p1_writeb), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_resp_valid(p1_resp_valid), .p1_rdata(p1_rdata),
    .mem_writeb(mem_writeb), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Single-port memory: acts at the rising edge, read returns the pre-write word.
  logic [31:0] env_mem [2048];
  logic [31:0] env_q;
  assign mem_rdata = env_q;
  initial begin
    for (int i = 0; i < 2048; i++) env_mem[i] = 32'd0;
    env_q = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_read) env_q <= env_mem[mem_addr];
      if (|mem_writeb) env_mem[mem_addr] <= merge(env_mem[mem_addr], mem_wdata, mem_writeb);
    end
  end

  // Reference model, evaluated once per cycle on the falling edge.
  logic [31:0] m_mem [2048];
  int          m_streak;
  bit          pv0, pv1;
  logic [31:0] pd0, pd1;
  initial begin
    bit g0, g1, rv0, rv1;
    for (int i = 0; i < 2048; i++) m_mem[i] = 32'd0;
    m_streak = 0; pv0 = 0; pv1 = 0; pd0 = 0; pd1 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        g0 = 0; g1 = 0;
      end else if (p0_valid && p1_valid) begin
        g1 = (m_streak == MS); g0 = !g1;
      end else begin
        g0 = p0_valid; g1 = p1_valid;
      end
      rv0 = pv0 && !rst;
      rv1 = pv1 && !rst;
      if (chk_en) begin
        chk("m_p0_ready", 32'(p0_ready), 32'(g0));
        chk("m_p1_ready", 32'(p1_ready), 32'(g1));
        chk("m_mem_read", 32'(mem_read), 32'(g0 ? p0_read : (g1 ? p1_read : 1'b0)));
        chk("m_mem_writeb", 32'(mem_writeb), 32'(g0 ? p0_writeb : (g1 ? p1_writeb : 4'd0)));
        if (g0 || g1) begin
          chk("m_mem_addr", 32'(mem_addr), 32'(g0 ? p0_addr : p1_addr));
          chk("m_mem_wdata", mem_wdata, g0 ? p0_wdata : p1_wdata);
        end
        chk("m_p0_resp_valid", 32'(p0_resp_valid), 32'(rv0));
        chk("m_p1_resp_valid", 32'(p1_resp_valid), 32'(rv1));
        chk("m_p0_rdata", p0_rdata, rv0 ? pd0 : 32'd0);
        chk("m_p1_rdata", p1_rdata, rv1 ? pd1 : 32'd0);
      end
      pv0 = g0 && p0_read;
      pv1 = g1 && p1_read;
      pd0 = m_mem[p0_addr];
      pd1 = m_mem[p1_addr];
      if (g0) m_mem[p0_addr] = merge(m_mem[p0_addr], p0_wdata, p0_writeb);
      if (g1) m_mem[p1_addr] = merge(m_mem[p1_addr], p1_wdata, p1_writeb);
      if (rst)                 m_streak = 0;
      else if (g0 && p1_valid) m_streak = (m_streak + 1 > MS) ? MS : m_streak + 1;
      else                     m_streak = 0;
    end
  end

  task automatic set0(input bit v, input bit rd, input logic [3:0] wb,
                      input logic [AW-1:0] a, input logic [31:0] d);
    p0_valid = v; p0_read = rd; p0_writeb = wb; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set1(input bit v, input bit rd, input logic [3:0] wb,
                      input logic [AW-1:0] a, input logic [31:0] d);
    p1_valid = v; p1_read = rd; p1_writeb = wb; p1_addr = a; p1_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] pat;
    bit acc0, acc1;
    set0(0, 0, 4'd0, '0, 32'd0);
    set1(0, 0, 4'd0, '0, 32'd0);
    rst = 1'b1;
    step();
    chk_en = 1'b1;

    set0(1, 1, 4'd0, '0, 32'd0);
    set1(1, 1, 4'd0, '0, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_p0_ready", 32'(p0_ready), 32'd0);
      chk("rst_p1_ready", 32'(p1_ready), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_writeb", 32'(mem_writeb), 32'd0);
      chk("rst_resp", 32'({p1_resp_valid, p0_resp_valid}), 32'd0);
      step();
    end
    rst = 1'b0;

    set0(1, 0, 4'hF, 11'h005, 32'hDEADBEEF);
    set1(0, 0, 4'd0, '0, 32'd0);
    @(negedge clk); chk("wr0_ready", 32'(p0_ready), 32'd1); step();
    set0(1, 1, 4'd0, 11'h005, 32'd0);
    @(negedge clk); chk("rd0_ready", 32'(p0_ready), 32'd1); step();
    set0(0, 0, 4'd0, '0, 32'd0);
    @(negedge clk);
    chk("rd0_resp_valid", 32'(p0_resp_valid), 32'd1);
    chk("rd0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("rd0_p1_resp_valid", 32'(p1_resp_valid), 32'd0);
    step();

    set1(1, 0, 4'hF, 11'h7FF, 32'hFFFFFFFF);
    @(negedge clk); chk("wr1_ready", 32'(p1_ready), 32'd1); step();
    set1(1, 0, 4'b0101, 11'h7FF, 32'h11223344); step();
    set1(1, 1, 4'd0, 11'h7FF, 32'd0); step();
    set1(0, 0, 4'd0, '0, 32'd0);
    @(negedge clk);
    chk("lane_resp_valid", 32'(p1_resp_valid), 32'd1);
    chk("lane_rdata", p1_rdata, 32'hFF22FF44);
    step();

    set0(1, 0, 4'hF, 11'h003, 32'h12345678); step();
    set0(1, 1, 4'hF, 11'h003, 32'hA5A5A5A5); step();
    set0(1, 1, 4'd0, 11'h003, 32'd0);
    @(negedge clk); chk("rdw_old", p0_rdata, 32'h12345678); step();
    set0(0, 0, 4'd0, '0, 32'd0);
    @(negedge clk); chk("rdw_new", p0_rdata, 32'hA5A5A5A5); step();

    // Contended reads: bit i set means port 1 should win cycle i.
    pat = 10'b10000_10000;
    set0(1, 1, 4'd0, 11'h010, 32'd0);
    set1(1, 1, 4'd0, 11'h020, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("ct_p1_grant", 32'(p1_ready), 32'(pat[i]));
      chk("ct_p0_grant", 32'(p0_ready), 32'(!pat[i]));
      step();
    end

    set0(0, 0, 4'd0, '0, 32'd0);
    set1(1, 1, 4'd0, 11'h7FF, 32'd0);
    @(negedge clk); chk("mr_accept", 32'(p1_ready), 32'd1); step();
    rst = 1'b1;
    @(negedge clk); chk("mr_dropped", 32'(p1_resp_valid), 32'd0); step();
    rst = 1'b0;
    @(negedge clk); chk("mr_regrant", 32'(p1_ready), 32'd1); step();
    set1(0, 0, 4'd0, '0, 32'd0);
    @(negedge clk);
    chk("mr_resp_valid", 32'(p1_resp_valid), 32'd1);
    chk("mr_rdata", p1_rdata, 32'hFF22FF44);
    step();

    repeat (3000) begin
      @(negedge clk);
      acc0 = p0_valid && p0_ready;
      acc1 = p1_valid && p1_ready;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      if (!p0_valid || acc0)
        set0(($urandom % 4) != 0, $urandom % 2, ($urandom % 2) ? 4'($urandom) : 4'd0,
             ($urandom % 8 == 0) ? 11'h7FF : 11'($urandom_range(0, 31)), $urandom);
      if (!p1_valid || acc1)
        set1(($urandom % 4) != 0, $urandom % 2, ($urandom % 2) ? 4'($urandom) : 4'd0,
             ($urandom % 8 == 0) ? 11'h7FF : 11'($urandom_range(0, 31)), $urandom);
    end

    rst = 1'b0;
    set0(0, 0, 4'd0, '0, 32'd0);
    set1(0, 0, 4'd0, '0, 32'd0);
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
